// File: rtl/memory_pkg.sv
// Definitions shared by the memory read and write units: request control
// bit positions, the handshake state encoding and the memory word width.
package memory_pkg;

  localparam int CTRL_OP    = 2;
  localparam int CTRL_MULTI = 1;
  localparam int CTRL_PIC   = 0;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_addr_gen.sv
// Row/column to linear word address: row*IMG_WIDTH + col + offset,
// wrapped to the memory port address width.
module mem_addr_gen #(
  parameter int IMG_WIDTH  = 256,
  parameter int MEM_ADDR_W = 16
) (
  input  logic [15:0]           i_row,
  input  logic [15:0]           i_col,
  input  logic [1:0]            i_offset,
  output logic [MEM_ADDR_W-1:0] o_addr
);

  localparam logic [31:0] WIDTH_U = 32'(IMG_WIDTH);

  logic [31:0] w_sum;

  // Full 32-bit sum first; only the low MEM_ADDR_W bits reach the port.
  assign w_sum  = {16'd0, i_row} * WIDTH_U + {16'd0, i_col} + {30'd0, i_offset};
  assign o_addr = MEM_ADDR_W'(w_sum);

endmodule

// File: rtl/memory_write.sv
// Write-side MEM-stage unit: latches a CPU write request and sequences one or
// three 16-bit beats into kernel/picture memory, then handshakes completion.
module memory_write
  import memory_pkg::*;
#(
  parameter int IMG_WIDTH  = 256,
  parameter int MEM_ADDR_W = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic [2:0]            CTRL,
  input  logic [31:0]           ADDRESS,
  input  logic [47:0]           DATA,
  input  logic                  MEM_READY,
  output logic                  MEM_WE,
  output logic                  MEM_SEL,
  output logic [MEM_ADDR_W-1:0] MEM_ADDR,
  output logic [WORD_W-1:0]     MEM_WDATA,
  output logic                  HANDSHAKE,
  output logic                  BUSY
);

  mem_state_t            r_state, w_state;
  logic [15:0]           r_row, w_row;
  logic [15:0]           r_col, w_col;
  logic [47:0]           r_data, w_data;
  logic                  r_multi, w_multi;
  logic                  r_sel, w_sel;
  logic [1:0]            r_idx, w_idx;
  logic                  r_we, w_we;
  logic                  r_hs, w_hs;
  logic                  r_busy, w_busy;
  logic [MEM_ADDR_W-1:0] r_addr, w_addr;
  logic [WORD_W-1:0]     r_wdata, w_wdata;
  logic [1:0]            w_last_idx;

  mem_addr_gen #(
    .IMG_WIDTH (IMG_WIDTH),
    .MEM_ADDR_W(MEM_ADDR_W)
  ) u_addr_gen (
    .i_row   (w_row),
    .i_col   (w_col),
    .i_offset(w_idx),
    .o_addr  (w_addr)
  );

  assign w_last_idx = r_multi ? 2'd2 : 2'd0;

  always_comb begin
    w_state = r_state;
    w_row   = r_row;
    w_col   = r_col;
    w_data  = r_data;
    w_multi = r_multi;
    w_sel   = r_sel;
    w_idx   = r_idx;
    w_we    = r_we;
    w_hs    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (ENABLE) begin
          w_row   = ADDRESS[31:16];
          w_col   = ADDRESS[15:0];
          w_data  = DATA;
          w_multi = CTRL[CTRL_MULTI];
          w_sel   = CTRL[CTRL_PIC];
          w_idx   = 2'd0;
          w_state = CTRL[CTRL_OP] ? ST_WRITE : ST_DONE;
        end
      end
      ST_WRITE: begin
        // First WRITE cycle only raises the strobe; beats advance on acceptance.
        if (!r_we) begin
          w_we  = 1'b1;
          w_idx = 2'd0;
        end else if (MEM_READY) begin
          if (r_idx == w_last_idx) begin
            w_we    = 1'b0;
            w_hs    = 1'b1;
            w_state = ST_DONE;
          end else begin
            w_idx = r_idx + 2'd1;
          end
        end
      end
      ST_DONE: begin
        w_hs = ENABLE;
        if (!ENABLE) w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (w_state == ST_WRITE);
    unique case (w_idx)
      2'd1:    w_wdata = w_data[31:16];
      2'd2:    w_wdata = w_data[47:32];
      default: w_wdata = w_data[15:0];
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_data  <= '0;
      r_multi <= 1'b0;
      r_sel   <= 1'b0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_hs    <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state;
      r_row   <= w_row;
      r_col   <= w_col;
      r_data  <= w_data;
      r_multi <= w_multi;
      r_sel   <= w_sel;
      r_idx   <= w_idx;
      r_we    <= w_we;
      r_hs    <= w_hs;
      r_busy  <= w_busy;
      if (w_we) begin
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
      end
    end
  end

  assign MEM_WE    = r_we;
  assign MEM_SEL   = r_sel;
  assign MEM_ADDR  = r_addr;
  assign MEM_WDATA = r_wdata;
  assign HANDSHAKE = r_hs;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_memory_write.sv
// Directed testbench for memory_write: single/multiple writes, backpressure,
// address wrap, no-op, early ENABLE drop and asynchronous reset mid-burst.
module tb_memory_write;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [2:0]  CTRL;
  logic [31:0] ADDRESS;
  logic [47:0] DATA;
  logic        MEM_READY;
  logic        MEM_WE;
  logic        MEM_SEL;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic        HANDSHAKE;
  logic        BUSY;

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;

  memory_write #(.IMG_WIDTH(256), .MEM_ADDR_W(16)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .CTRL     (CTRL),
    .ADDRESS  (ADDRESS),
    .DATA     (DATA),
    .MEM_READY(MEM_READY),
    .MEM_WE   (MEM_WE),
    .MEM_SEL  (MEM_SEL),
    .MEM_ADDR (MEM_ADDR),
    .MEM_WDATA(MEM_WDATA),
    .HANDSHAKE(HANDSHAKE),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (MEM_WE && MEM_READY) beats++;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESET = 1'b0; ENABLE = 1'b0; CTRL = 3'b000; ADDRESS = '0; DATA = '0; MEM_READY = 1'b1;
    tick(); tick();
    n_checks++; if ({MEM_WE, MEM_SEL, HANDSHAKE, BUSY} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {MEM_WE, MEM_SEL, HANDSHAKE, BUSY}); end
    n_checks++; if ({MEM_ADDR, MEM_WDATA} !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=00000000", {MEM_ADDR, MEM_WDATA}); end
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_single;
    int b0;
    b0 = beats;
    ENABLE = 1'b1; CTRL = 3'b101; ADDRESS = 32'h00010002; DATA = 48'h1111_2222_00b7; MEM_READY = 1'b1;
    tick(); // edge 0
    CTRL = 3'b000; ADDRESS = '0; DATA = '0;
    n_checks++; if ({MEM_WE, BUSY, HANDSHAKE} !== 3'b010) begin n_fail++; $display("FAIL single_e0 got=%b exp=010", {MEM_WE, BUSY, HANDSHAKE}); end
    tick(); // edge 1
    n_checks++; if ({MEM_WE, MEM_SEL} !== 2'b11) begin n_fail++; $display("FAIL single_we_sel got=%b exp=11", {MEM_WE, MEM_SEL}); end
    n_checks++; if (MEM_ADDR !== 16'h0102) begin n_fail++; $display("FAIL single_addr got=%h exp=0102", MEM_ADDR); end
    n_checks++; if (MEM_WDATA !== 16'h00b7) begin n_fail++; $display("FAIL single_wdata got=%h exp=00b7", MEM_WDATA); end
    tick(); // edge 2
    n_checks++; if ({MEM_WE, HANDSHAKE, BUSY} !== 3'b010) begin n_fail++; $display("FAIL single_e2 got=%b exp=010", {MEM_WE, HANDSHAKE, BUSY}); end
    tick();
    n_checks++; if (HANDSHAKE !== 1'b1) begin n_fail++; $display("FAIL single_hs_hold got=%b exp=1", HANDSHAKE); end
    ENABLE = 1'b0;
    tick();
    n_checks++; if (HANDSHAKE !== 1'b0) begin n_fail++; $display("FAIL single_hs_fall got=%b exp=0", HANDSHAKE); end
    n_checks++; if (beats - b0 !== 1) begin n_fail++; $display("FAIL single_beats got=%0d exp=1", beats - b0); end
  endtask

  task automatic test_multi(input logic [31:0] addr, input logic [2:0] ctrl, input logic [47:0] data,
                            input logic [15:0] ea0, input logic [15:0] ea1, input logic [15:0] ea2, input string name);
    logic [15:0] ea [3];
    logic [15:0] ed [3];
    int b0;
    ea[0] = ea0; ea[1] = ea1; ea[2] = ea2;
    ed[0] = data[15:0]; ed[1] = data[31:16]; ed[2] = data[47:32];
    b0 = beats;
    ENABLE = 1'b1; CTRL = ctrl; ADDRESS = addr; DATA = data; MEM_READY = 1'b1;
    tick(); // edge 0
    CTRL = 3'b000; ADDRESS = '0; DATA = '0;
    for (int i = 0; i < 3; i++) begin
      tick(); // edges 1..3
      n_checks++; if ({MEM_WE, MEM_SEL, HANDSHAKE, BUSY} !== {1'b1, ctrl[0], 1'b0, 1'b1}) begin n_fail++; $display("FAIL %s_ctl%0d got=%b exp=%b", name, i, {MEM_WE, MEM_SEL, HANDSHAKE, BUSY}, {1'b1, ctrl[0], 2'b01}); end
      n_checks++; if ({MEM_ADDR, MEM_WDATA} !== {ea[i], ed[i]}) begin n_fail++; $display("FAIL %s_beat%0d got=%h exp=%h", name, i, {MEM_ADDR, MEM_WDATA}, {ea[i], ed[i]}); end
    end
    tick(); // edge 4
    n_checks++; if ({MEM_WE, HANDSHAKE, BUSY} !== 3'b010) begin n_fail++; $display("FAIL %s_e4 got=%b exp=010", name, {MEM_WE, HANDSHAKE, BUSY}); end
    ENABLE = 1'b0;
    tick();
    n_checks++; if (HANDSHAKE !== 1'b0) begin n_fail++; $display("FAIL %s_hs_fall got=%b exp=0", name, HANDSHAKE); end
    n_checks++; if (beats - b0 !== 3) begin n_fail++; $display("FAIL %s_beats got=%0d exp=3", name, beats - b0); end
  endtask

  task automatic test_backpressure;
    int b0;
    b0 = beats;
    ENABLE = 1'b1; CTRL = 3'b110; ADDRESS = 32'h00020001; DATA = 48'h00b100b300b3; MEM_READY = 1'b1;
    tick(); // edge 0
    tick(); // edge 1: beat 0
    tick(); // edge 2: beat 1 presented
    MEM_READY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); // edges 3,4 stalled
      n_checks++; if ({MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, 16'h0202, 16'h00b3}) begin n_fail++; $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/0202/00b3", i, MEM_WE, MEM_ADDR, MEM_WDATA); end
    end
    MEM_READY = 1'b1;
    tick(); // edge 5
    n_checks++; if ({MEM_ADDR, MEM_WDATA} !== 32'h0203_00b1) begin n_fail++; $display("FAIL bp_beat2 got=%h exp=020300b1", {MEM_ADDR, MEM_WDATA}); end
    n_checks++; if (HANDSHAKE !== 1'b0) begin n_fail++; $display("FAIL bp_hs_early got=%b exp=0", HANDSHAKE); end
    tick(); // edge 6
    n_checks++; if ({MEM_WE, HANDSHAKE} !== 2'b01) begin n_fail++; $display("FAIL bp_e6 got=%b exp=01", {MEM_WE, HANDSHAKE}); end
    n_checks++; if (beats - b0 !== 3) begin n_fail++; $display("FAIL bp_beats got=%0d exp=3", beats - b0); end
    ENABLE = 1'b0;
    tick();
  endtask

  task automatic test_noop;
    int b0;
    b0 = beats;
    ENABLE = 1'b1; CTRL = 3'b000; ADDRESS = 32'h00030004; DATA = 48'h1;
    tick(); // edge 0
    n_checks++; if ({MEM_WE, HANDSHAKE, BUSY} !== 3'b000) begin n_fail++; $display("FAIL noop_e0 got=%b exp=000", {MEM_WE, HANDSHAKE, BUSY}); end
    tick(); // edge 1
    n_checks++; if ({MEM_WE, HANDSHAKE} !== 2'b01) begin n_fail++; $display("FAIL noop_e1 got=%b exp=01", {MEM_WE, HANDSHAKE}); end
    ENABLE = 1'b0;
    tick();
    n_checks++; if (HANDSHAKE !== 1'b0) begin n_fail++; $display("FAIL noop_hs_fall got=%b exp=0", HANDSHAKE); end
    n_checks++; if (beats - b0 !== 0) begin n_fail++; $display("FAIL noop_beats got=%0d exp=0", beats - b0); end
  endtask

  task automatic test_early_drop;
    int b0;
    b0 = beats;
    ENABLE = 1'b1; CTRL = 3'b110; ADDRESS = 32'h00020001; DATA = 48'h00b100b300b3; MEM_READY = 1'b1;
    tick(); tick(); tick(); // edges 0..2
    ENABLE = 1'b0;
    tick(); // edge 3
    n_checks++; if ({MEM_WE, MEM_ADDR} !== {1'b1, 16'h0203}) begin n_fail++; $display("FAIL drop_beat2 got=%b/%h exp=1/0203", MEM_WE, MEM_ADDR); end
    tick(); // edge 4
    n_checks++; if ({MEM_WE, HANDSHAKE} !== 2'b01) begin n_fail++; $display("FAIL drop_hs got=%b exp=01", {MEM_WE, HANDSHAKE}); end
    tick(); // edge 5
    n_checks++; if ({HANDSHAKE, BUSY} !== 2'b00) begin n_fail++; $display("FAIL drop_hs_once got=%b exp=00", {HANDSHAKE, BUSY}); end
    n_checks++; if (beats - b0 !== 3) begin n_fail++; $display("FAIL drop_beats got=%0d exp=3", beats - b0); end
    tick();
    n_checks++; if (HANDSHAKE !== 1'b0) begin n_fail++; $display("FAIL drop_idle got=%b exp=0", HANDSHAKE); end
  endtask

  task automatic test_reset_mid_burst;
    ENABLE = 1'b1; CTRL = 3'b111; ADDRESS = 32'h00020001; DATA = 48'h00b100b300b3; MEM_READY = 1'b1;
    tick(); tick(); tick(); // edges 0..2: second beat on the port
    #2;
    RESET = 1'b0;
    #1;
    n_checks++; if ({MEM_WE, MEM_SEL, HANDSHAKE, BUSY} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ctrl got=%b exp=0000", {MEM_WE, MEM_SEL, HANDSHAKE, BUSY}); end
    n_checks++; if ({MEM_ADDR, MEM_WDATA} !== 32'h0) begin n_fail++; $display("FAIL rstmid_data got=%h exp=00000000", {MEM_ADDR, MEM_WDATA}); end
    ENABLE = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    n_checks++; if ({MEM_WE, HANDSHAKE, BUSY} !== 3'b000) begin n_fail++; $display("FAIL rstmid_idle got=%b exp=000", {MEM_WE, HANDSHAKE, BUSY}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi(32'h00020001, 3'b110, 48'h00b100b300b3, 16'h0201, 16'h0202, 16'h0203, "multi");
    test_backpressure();
    test_multi(32'h00FF00FF, 3'b111, 48'h333322221111, 16'hFFFF, 16'h0000, 16'h0001, "wrap");
    test_noop();
    test_early_drop();
    test_reset_mid_burst();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
